// File: rtl/mapped_io_irq.sv
// rtl/mapped_io_irq.sv - memory-mapped LED/7-seg/switch/button slave with maskable level interrupt
module mapped_io_irq #(
    parameter logic [15:0] BASE_HI    = 16'hBF80,
    parameter int          SW_W       = 8,
    parameter int          PB_W       = 3,
    parameter int          LED_W      = 8,
    parameter int          DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       addr,
    input  logic [31:0]       datain,
    input  logic              we,
    output logic [31:0]       dataout,
    output logic              irq,
    input  logic [SW_W-1:0]   IO_Switch,
    input  logic [PB_W-1:0]   IO_PB,
    output logic [LED_W-1:0]  IO_LED,
    output logic [7:0]        IO_7SEGEN_N,
    output logic [31:0]       IO_7SEG_DATA
);

    localparam int PW = PB_W + 1;
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [7:0] OFF_LED   = 8'h00;
    localparam logic [7:0] OFF_SW    = 8'h04;
    localparam logic [7:0] OFF_PB    = 8'h08;
    localparam logic [7:0] OFF_SEGEN = 8'h0C;
    localparam logic [7:0] OFF_SEGD  = 8'h10;
    localparam logic [7:0] OFF_PEND  = 8'h14;
    localparam logic [7:0] OFF_EN    = 8'h18;

    logic [SW_W-1:0] sw_s1, sw_s2, sw_prev;
    logic [PB_W-1:0] pb_s1, pb_s2, pb_deb, pb_deb_prev;
    logic [CW-1:0]   deb_cnt [PB_W];
    logic [PW-1:0]   pend, en;
    logic [PW-1:0]   pend_set, pend_clr;
    logic [31:0]     rdata;
    logic            sel, wr;
    logic [7:0]      offset;
    logic            unused_addr_bits;

    assign sel    = (addr[31:16] == BASE_HI);
    assign offset = addr[7:0];
    assign wr     = we && sel;
    // Only addr[7:0] selects a register inside the window.
    assign unused_addr_bits = ^addr[15:8];

    // A source fires on a debounced button rising edge or any synced switch change.
    assign pend_set = {(sw_s2 != sw_prev), (pb_deb & ~pb_deb_prev)};
    assign pend_clr = (wr && offset == OFF_PEND) ? datain[PW-1:0] : '0;
    assign irq      = |(pend & en);

    // Two-flop synchronisers for the asynchronous inputs plus the switch snapshot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_prev <= '0;
            pb_s1   <= '0;
            pb_s2   <= '0;
        end else begin
            sw_s1   <= IO_Switch;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
            pb_s1   <= IO_PB;
            pb_s2   <= pb_s1;
        end
    end

    // Per-button debounce: deb follows synced only after it has differed for DEB_CYCLES cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pb_deb      <= '0;
            pb_deb_prev <= '0;
            for (int i = 0; i < PB_W; i++) deb_cnt[i] <= '0;
        end else begin
            pb_deb_prev <= pb_deb;
            for (int i = 0; i < PB_W; i++) begin
                if (pb_s2[i] == pb_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    pb_deb[i]  <= pb_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Writable registers; a new pending event wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            IO_LED       <= '0;
            IO_7SEGEN_N  <= '0;
            IO_7SEG_DATA <= '0;
            en           <= '0;
            pend         <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
            if (wr) begin
                case (offset)
                    OFF_LED:   IO_LED       <= datain[LED_W-1:0];
                    OFF_SEGEN: IO_7SEGEN_N  <= datain[7:0];
                    OFF_SEGD:  IO_7SEG_DATA <= datain;
                    OFF_EN:    en           <= datain[PW-1:0];
                    default:   ;
                endcase
            end
        end
    end

    // Read mux, zero-extended; unmapped offsets read 0.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_LED:   rdata[LED_W-1:0] = IO_LED;
            OFF_SW:    rdata[SW_W-1:0]  = sw_s2;
            OFF_PB:    rdata[PB_W-1:0]  = pb_deb;
            OFF_SEGEN: rdata[7:0]       = IO_7SEGEN_N;
            OFF_SEGD:  rdata            = IO_7SEG_DATA;
            OFF_PEND:  rdata[PW-1:0]    = pend;
            OFF_EN:    rdata[PW-1:0]    = en;
            default:   rdata            = '0;
        endcase
    end

    // Registered read data, one cycle latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) dataout <= '0;
        else         dataout <= sel ? rdata : 32'h0;
    end

endmodule
